bmult_prod_accum: RTL

//  Downstream of the registered 26x26 limb multiplier. Takes its 52-bit partial products plus a

---
 rtl/bmult_pkg.sv | 17 +
 rtl/pacc_carry_step.sv | 22 ++
 rtl/bmult_prod_accum.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bmult_pkg.sv
// Shared definitions for the limb-multiplier product accumulator.
// Holds the default limb geometry, the accumulator FSM states and the accumulator width rule.
package bmult_pkg;

   localparam int PACC_LIMB_W = 26;
   localparam int PACC_NLIMB  = 4;

   typedef enum logic [1:0] {ACCUM, NORM, DONE} pacc_state_t;

   // Column accumulator width: a 2*LIMB_W product plus headroom for NLIMB products per column.
   function automatic int pacc_acc_w(input int limb_w, input int nlimb);
      return 2 * limb_w + $clog2(nlimb) + 1;
   endfunction

   localparam int PACC_ACC_W = pacc_acc_w(PACC_LIMB_W, PACC_NLIMB);

endpackage

// File: rtl/pacc_carry_step.sv
// One limb of carry normalisation: adds the incoming carry to a column sum and
// splits the result into the output limb and the carry passed to the next column.
module pacc_carry_step #(
   parameter int LIMB_W  = 26,
   parameter int ACC_W   = 55,
   parameter int CARRY_W = 30
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [CARRY_W-1:0] carry_in,
   output logic [LIMB_W-1:0]  limb,
   output logic [CARRY_W-1:0] carry_out
);

   logic [ACC_W:0] sum;

   always_comb begin
      sum       = {1'b0, acc} + {{(ACC_W + 1 - CARRY_W){1'b0}}, carry_in};
      limb      = sum[LIMB_W-1:0];
      carry_out = sum[ACC_W:LIMB_W];
   end

endmodule

// File: rtl/bmult_prod_accum.sv
// Column accumulator and limb-serial carry normaliser behind the 26x26 limb multiplier.
// Optional feature macro: PACC_ERR_CHECK_EN adds the sticky err output.
module bmult_prod_accum
   import bmult_pkg::*;
#(
   parameter int LIMB_W = PACC_LIMB_W,
   parameter int NLIMB  = PACC_NLIMB
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2*LIMB_W-1:0]           in_prod,
   input  logic [$clog2(2*NLIMB)-1:0]    in_col,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [2*NLIMB*LIMB_W-1:0]     out_data
`ifdef PACC_ERR_CHECK_EN
   ,
   output logic                          err
`endif
);

   localparam int NCOL    = 2 * NLIMB;
   localparam int COL_W   = $clog2(NCOL);
   localparam int K_W     = COL_W + 1;
   localparam int ACC_W   = pacc_acc_w(LIMB_W, NLIMB);
   localparam int CARRY_W = ACC_W + 1 - LIMB_W;
   localparam int OUT_W   = NCOL * LIMB_W;

   localparam logic [COL_W-1:0] MAX_COL = COL_W'(NCOL - 2);
   localparam logic [K_W-1:0]   K_END   = K_W'(NCOL);

   pacc_state_t         state_q, state_d;
   logic [ACC_W-1:0]    acc_q [NCOL];
   logic [ACC_W-1:0]    acc_d [NCOL];
   logic [K_W-1:0]      k_q, k_d;
   logic [CARRY_W-1:0]  carry_q, carry_d;
   logic [OUT_W-1:0]    out_data_q, out_data_d;
`ifdef PACC_ERR_CHECK_EN
   logic                err_q, err_d;
`endif

   logic [LIMB_W-1:0]   step_limb;
   logic [CARRY_W-1:0]  step_carry;

   pacc_carry_step #(
      .LIMB_W  (LIMB_W),
      .ACC_W   (ACC_W),
      .CARRY_W (CARRY_W)
   ) u_carry_step (
      .acc       (acc_q[k_q[COL_W-1:0]]),
      .carry_in  (carry_q),
      .limb      (step_limb),
      .carry_out (step_carry)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      k_d        = k_q;
      carry_d    = carry_q;
      out_data_d = out_data_q;
`ifdef PACC_ERR_CHECK_EN
      err_d      = err_q;
`endif
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Top column index has no partial products; such beats are consumed and dropped.
               if (in_col <= MAX_COL) begin
                  acc_d[in_col] = acc_q[in_col] + ACC_W'(in_prod);
               end else begin
`ifdef PACC_ERR_CHECK_EN
                  err_d = 1'b1;
`endif
               end
               if (in_last) begin
                  state_d = NORM;
                  k_d     = '0;
                  carry_d = '0;
               end
            end
         end
         NORM: begin
            // k runs one past the last limb so the final carry is judged on its own edge.
            if (k_q == K_END) begin
               state_d = DONE;
`ifdef PACC_ERR_CHECK_EN
               if (carry_q != '0) err_d = 1'b1;
`endif
            end else begin
               for (int unsigned i = 0; i < NCOL; i++) begin
                  if (k_q == K_W'(i)) out_data_d[i*LIMB_W +: LIMB_W] = step_limb;
               end
               carry_d = step_carry;
               k_d     = k_q + K_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ACCUM;
               for (int unsigned i = 0; i < NCOL; i++) acc_d[i] = '0;
               carry_d = '0;
`ifdef PACC_ERR_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         acc_q      <= '{default: '0};
         k_q        <= '0;
         carry_q    <= '0;
         out_data_q <= '0;
`ifdef PACC_ERR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         k_q        <= k_d;
         carry_q    <= carry_d;
         out_data_q <= out_data_d;
`ifdef PACC_ERR_CHECK_EN
         err_q      <= err_d;
`endif
      end
   end

   assign out_data = out_data_q;
`ifdef PACC_ERR_CHECK_EN
   assign err      = err_q;
`endif

endmodule
